// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- signal bundle for mem_arbiter.
// Carries the instruction-fetch port (i_*), the data port (d_*), the backing
// memory port (mem_*) and the fetch stall counter.
//   slave  : the arbiter's view (consumes requests and memory responses).
//   master : the environment's view (CPU front end plus backing memory).
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // instruction fetch port
  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_hit_o;
  logic [DW-1:0] i_rdata_o;
  // data port
  logic          d_req_i;
  logic          d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_hit_o;
  logic [DW-1:0] d_rdata_o;
  // backing memory port
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ready_i;
  logic [DW-1:0] mem_rdata_i;
  // fetch stall statistics
  logic [31:0]   stall_cnt_o;

  modport slave (
    input  i_req_i, i_addr_i,
    output i_hit_o, i_rdata_o,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output d_hit_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ready_i, mem_rdata_i,
    output stall_cnt_o
  );

  modport master (
    output i_req_i, i_addr_i,
    input  i_hit_o, i_rdata_o,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  d_hit_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ready_i, mem_rdata_i,
    input  stall_cnt_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one backing-memory port between an instruction fetch
// port and a data port, with a single-entry instruction buffer in front of
// the fetch path.
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_ni : synchronous active-low reset
//   bus    : mem_arbiter_if.slave
//            i_req_i/i_addr_i -> i_hit_o/i_rdata_o   fetch (served from buffer)
//            d_req_i/d_we_i/d_addr_i/d_wdata_i -> d_hit_o/d_rdata_o
//            mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o <- mem_ready_i/mem_rdata_i
//            stall_cnt_o : saturating count of fetch-miss cycles
// Data has fixed priority over fetch; one transaction is outstanding at a time
// and the memory may take any number of cycles to answer.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state;

  // single-entry instruction buffer
  logic          ibuf_valid;
  logic [AW-1:0] ibuf_addr;
  logic [DW-1:0] ibuf_data;

  // latched transaction driven straight onto the memory port
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic [31:0]   stall_cnt;

  logic          i_hit_raw;
  logic          fetch_miss;
  logic          d_done;
  logic          wr_hits_ibuf;

  assign i_hit_raw  = bus.i_req_i & ibuf_valid & (ibuf_addr == bus.i_addr_i);
  assign fetch_miss = bus.i_req_i & ~i_hit_raw;
  assign d_done     = (state == BUSY_D) & bus.mem_ready_i;

  // A completing store to the buffered word would leave stale code behind,
  // so it knocks the buffer out on the same edge (self-modifying code).
  assign wr_hits_ibuf = mem_we & ibuf_valid &
                        (mem_addr[AW-1:2] == ibuf_addr[AW-1:2]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // Abandons any transaction in flight without waiting for the memory.
      state      <= IDLE;
      ibuf_valid <= 1'b0;
      ibuf_addr  <= '0;
      ibuf_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (fetch_miss && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end

      case (state)
        IDLE: begin
          if (bus.d_req_i) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= bus.d_we_i;
            mem_addr  <= bus.d_addr_i;
            mem_wdata <= bus.d_wdata_i;
          end else if (fetch_miss) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= bus.i_addr_i;
            mem_wdata <= '0;
          end
        end

        BUSY_I: begin
          // The fill uses the latched address, so a redirect during the
          // fetch still completes and simply leaves the old line buffered.
          if (bus.mem_ready_i) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            ibuf_valid <= 1'b1;
            ibuf_addr  <= mem_addr;
            ibuf_data  <= bus.mem_rdata_i;
          end
        end

        BUSY_D: begin
          if (bus.mem_ready_i) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (wr_hits_ibuf) begin
              ibuf_valid <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out before
  // the first reset edge has cleared the registers.
  assign bus.i_hit_o     = rst_ni & i_hit_raw;
  assign bus.i_rdata_o   = rst_ni ? ibuf_data : '0;
  assign bus.d_hit_o     = rst_ni & d_done;
  assign bus.d_rdata_o   = (rst_ni && d_done && !mem_we) ? bus.mem_rdata_i : '0;
  assign bus.mem_req_o   = rst_ni & mem_req;
  assign bus.mem_we_o    = rst_ni & mem_we;
  assign bus.mem_addr_o  = rst_ni ? mem_addr : '0;
  assign bus.mem_wdata_o = rst_ni ? mem_wdata : '0;
  assign bus.stall_cnt_o = rst_ni ? stall_cnt : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed scenarios plus a randomized mix of fetches and
// data accesses. The bench plays the CPU and the backing memory; expected
// values come from a reference memory image, a model of which instruction
// address is currently buffered, and a count of fetch-miss cycles.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // phys: the memory contents as the backing store sees them
  // ref_mem: what the CPU's program order says memory should hold
  logic [DW-1:0] phys    [128];
  logic [DW-1:0] ref_mem [128];
  logic          mvalid;
  logic [AW-1:0] maddr;
  logic [31:0]   exp_stall;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // A fetch hits when the requested byte address is the one last filled and
  // no store to that word has happened since.
  function automatic logic model_hit();
    return bus.i_req_i && mvalid && (maddr == bus.i_addr_i);
  endfunction

  // One clock: account for a stall cycle, then move to the next falling edge.
  task automatic tick();
    if (rst_ni && bus.i_req_i && !model_hit() && (exp_stall != 32'hFFFF_FFFF))
      exp_stall++;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive_idle();
    bus.i_req_i     = 1'b0;
    bus.i_addr_i    = '0;
    bus.d_req_i     = 1'b0;
    bus.d_we_i      = 1'b0;
    bus.d_addr_i    = '0;
    bus.d_wdata_i   = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  task automatic chk_zero(input string p);
    chk1({p, "_i_hit"},     bus.i_hit_o,     1'b0);
    chk32({p, "_i_rdata"},  bus.i_rdata_o,   32'h0);
    chk1({p, "_d_hit"},     bus.d_hit_o,     1'b0);
    chk32({p, "_d_rdata"},  bus.d_rdata_o,   32'h0);
    chk1({p, "_mem_req"},   bus.mem_req_o,   1'b0);
    chk1({p, "_mem_we"},    bus.mem_we_o,    1'b0);
    chk32({p, "_mem_addr"}, bus.mem_addr_o,  32'h0);
    chk32({p, "_mem_wdat"}, bus.mem_wdata_o, 32'h0);
    chk32({p, "_stall"},    bus.stall_cnt_o, 32'h0);
  endtask

  // CPU data access held until its hit; memory answers after lat wait cycles.
  task automatic data_op(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat);
    bus.i_req_i     = 1'b0;
    bus.d_req_i     = 1'b1;
    bus.d_we_i      = we;
    bus.d_addr_i    = addr;
    bus.d_wdata_i   = wdata;
    bus.mem_ready_i = 1'b0;
    tick();
    chk1("d_mem_req", bus.mem_req_o, 1'b1);
    chk1("d_mem_we", bus.mem_we_o, we);
    chk32("d_mem_addr", bus.mem_addr_o, addr);
    if (we) chk32("d_mem_wdata", bus.mem_wdata_o, wdata);
    chk1("d_hit_early", bus.d_hit_o, 1'b0);
    for (int k = 0; k < lat; k++) begin
      tick();
      chk1("d_req_hold", bus.mem_req_o, 1'b1);
      chk32("d_addr_hold", bus.mem_addr_o, addr);
      chk1("d_hit_wait", bus.d_hit_o, 1'b0);
    end
    bus.mem_ready_i = 1'b1;
    if (!we) bus.mem_rdata_i = phys[bus.mem_addr_o[8:2]];
    #1;
    chk1("d_hit_done", bus.d_hit_o, 1'b1);
    if (!we) chk32("d_rdata", bus.d_rdata_o, ref_mem[addr[8:2]]);
    if (we && bus.mem_we_o) phys[bus.mem_addr_o[8:2]] = bus.mem_wdata_o;
    tick();
    bus.d_req_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = $urandom;
    if (we) begin
      ref_mem[addr[8:2]] = wdata;
      if (mvalid && (maddr[AW-1:2] == addr[AW-1:2])) mvalid = 1'b0;
    end
    #1;
    chk1("d_hit_once", bus.d_hit_o, 1'b0);
    chk1("d_req_after", bus.mem_req_o, 1'b0);
    tick();
    chk1("d_no_reissue", bus.mem_req_o, 1'b0);
    chk32("d_stall", bus.stall_cnt_o, exp_stall);
  endtask

  // CPU fetch held until it hits; memory answers a miss after lat wait cycles.
  task automatic fetch_op(input logic [AW-1:0] addr, input int lat);
    logic h;
    bus.d_req_i     = 1'b0;
    bus.i_req_i     = 1'b1;
    bus.i_addr_i    = addr;
    bus.mem_ready_i = 1'b0;
    #1;
    h = model_hit();
    chk1("f_hit_first", bus.i_hit_o, h);
    if (h) begin
      chk32("f_rdata_hit", bus.i_rdata_o, ref_mem[addr[8:2]]);
      tick();
      chk1("f_hit_no_mem", bus.mem_req_o, 1'b0);
    end else begin
      tick();
      chk1("f_mem_req", bus.mem_req_o, 1'b1);
      chk1("f_mem_we", bus.mem_we_o, 1'b0);
      chk32("f_mem_addr", bus.mem_addr_o, addr);
      for (int k = 0; k < lat; k++) begin
        tick();
        chk1("f_req_hold", bus.mem_req_o, 1'b1);
        chk32("f_addr_hold", bus.mem_addr_o, addr);
      end
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = phys[bus.mem_addr_o[8:2]];
      #1;
      chk1("f_hit_before_fill", bus.i_hit_o, 1'b0);
      tick();
      mvalid = 1'b1;
      maddr  = addr;
      bus.mem_ready_i = 1'b0;
      bus.mem_rdata_i = $urandom;
      #1;
      chk1("f_hit_after_fill", bus.i_hit_o, 1'b1);
      chk32("f_rdata", bus.i_rdata_o, ref_mem[addr[8:2]]);
      chk1("f_idle_after", bus.mem_req_o, 1'b0);
    end
    chk32("f_stall", bus.stall_cnt_o, exp_stall);
    bus.i_req_i = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int unsigned   kind;

    for (int w = 0; w < 128; w++) begin
      phys[w]    = $urandom;
      ref_mem[w] = phys[w];
    end
    mvalid    = 1'b0;
    maddr     = '0;
    exp_stall = '0;

    // Reset with every request and the memory ready asserted.
    drive_idle();
    rst_ni          = 1'b0;
    bus.i_req_i     = 1'b1;
    bus.d_req_i     = 1'b1;
    bus.d_we_i      = 1'b1;
    bus.d_addr_i    = 32'h0000_0040;
    bus.d_wdata_i   = 32'h1234_5678;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    tick();
    tick();
    chk_zero("rst");
    drive_idle();
    rst_ni = 1'b1;
    #1;
    chk_zero("post_rst");

    // Fetch miss of 0x0, memory answers on the second busy cycle.
    phys[0]    = 32'h2010_0005;
    ref_mem[0] = 32'h2010_0005;
    fetch_op(32'h0, 1);
    chk32("miss0_rdata", bus.i_rdata_o, 32'h2010_0005);
    chk32("miss0_stall", bus.stall_cnt_o, 32'd3);

    // Store and fetch miss in the same cycle: store goes first.
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h0000_0100;
    bus.d_wdata_i = 32'hDEAD_BEEF;
    bus.i_req_i   = 1'b1;
    bus.i_addr_i  = 32'h0000_0004;
    #1;
    chk1("col_i_hit0", bus.i_hit_o, 1'b0);
    tick();
    chk1("col_d_req", bus.mem_req_o, 1'b1);
    chk1("col_d_we", bus.mem_we_o, 1'b1);
    chk32("col_d_addr", bus.mem_addr_o, 32'h0000_0100);
    chk32("col_d_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
    bus.mem_ready_i = 1'b1;
    #1;
    chk1("col_d_hit", bus.d_hit_o, 1'b1);
    if (bus.mem_we_o) phys[bus.mem_addr_o[8:2]] = bus.mem_wdata_o;
    tick();
    bus.d_req_i     = 1'b0;
    bus.mem_ready_i = 1'b0;
    ref_mem[64]     = 32'hDEAD_BEEF;
    #1;
    chk1("col_idle_gap", bus.mem_req_o, 1'b0);
    chk1("col_d_hit_once", bus.d_hit_o, 1'b0);
    tick();
    chk1("col_f_req", bus.mem_req_o, 1'b1);
    chk1("col_f_we", bus.mem_we_o, 1'b0);
    chk32("col_f_addr", bus.mem_addr_o, 32'h0000_0004);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = phys[bus.mem_addr_o[8:2]];
    #1;
    chk1("col_no_d_hit", bus.d_hit_o, 1'b0);
    tick();
    mvalid = 1'b1;
    maddr  = 32'h0000_0004;
    bus.mem_ready_i = 1'b0;
    #1;
    chk1("col_f_hit", bus.i_hit_o, 1'b1);
    chk32("col_f_rdata", bus.i_rdata_o, ref_mem[1]);
    chk32("col_stall", bus.stall_cnt_o, 32'd7);
    bus.i_req_i = 1'b0;
    data_op(1'b0, 32'h0000_0100, 32'h0, 0);

    // Self-modifying store to the buffered word forces a refetch.
    fetch_op(32'h0000_0008, 0);
    fetch_op(32'h0000_0008, 0);
    data_op(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 1);
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0008;
    #1;
    chk1("smc_no_hit", bus.i_hit_o, 1'b0);
    fetch_op(32'h0000_0008, 2);
    chk32("smc_new_code", bus.i_rdata_o, 32'hCAFE_F00D);

    // Redirect while a fetch is in flight.
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0010;
    tick();
    chk32("redir_addr0", bus.mem_addr_o, 32'h0000_0010);
    bus.i_addr_i = 32'h0000_0040;
    tick();
    chk1("redir_hold_req", bus.mem_req_o, 1'b1);
    chk32("redir_hold_addr", bus.mem_addr_o, 32'h0000_0010);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = phys[bus.mem_addr_o[8:2]];
    tick();
    mvalid = 1'b1;
    maddr  = 32'h0000_0010;
    bus.mem_ready_i = 1'b0;
    #1;
    chk1("redir_stale_miss", bus.i_hit_o, 1'b0);
    tick();
    chk1("redir_new_req", bus.mem_req_o, 1'b1);
    chk32("redir_new_addr", bus.mem_addr_o, 32'h0000_0040);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = phys[bus.mem_addr_o[8:2]];
    tick();
    maddr = 32'h0000_0040;
    bus.mem_ready_i = 1'b0;
    #1;
    chk1("redir_hit", bus.i_hit_o, 1'b1);
    chk32("redir_rdata", bus.i_rdata_o, ref_mem[16]);
    chk32("redir_stall", bus.stall_cnt_o, exp_stall);
    bus.i_req_i = 1'b0;

    // Random mix of reads, writes and fetches.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      wd   = $urandom;
      if (kind < 3) begin
        a = AW'($urandom_range(0, 31) << 2);
        data_op(1'b1, a, wd, int'($urandom_range(0, 3)));
      end else if (kind < 6) begin
        a = AW'($urandom_range(0, 31) << 2);
        data_op(1'b0, a, wd, int'($urandom_range(0, 3)));
      end else begin
        a = AW'($urandom_range(0, 5) << 2);
        fetch_op(a, int'($urandom_range(0, 3)));
      end
    end

    // Reset while a store is waiting on the memory.
    fetch_op(32'h0000_000C, 0);
    bus.d_req_i   = 1'b1;
    bus.d_we_i    = 1'b1;
    bus.d_addr_i  = 32'h0000_0020;
    bus.d_wdata_i = 32'h5555_AAAA;
    tick();
    chk1("rstb_busy", bus.mem_req_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_zero("rstb_now");
    tick();
    bus.mem_ready_i = 1'b1;
    #1;
    chk_zero("rstb_held");
    tick();
    bus.d_req_i = 1'b0;
    rst_ni      = 1'b1;
    mvalid      = 1'b0;
    exp_stall   = '0;
    #1;
    chk1("rstb_rel_d_hit", bus.d_hit_o, 1'b0);
    chk1("rstb_rel_req", bus.mem_req_o, 1'b0);
    tick();
    chk1("rstb_after_d_hit", bus.d_hit_o, 1'b0);
    chk1("rstb_after_req", bus.mem_req_o, 1'b0);
    chk1("rstb_after_we", bus.mem_we_o, 1'b0);
    bus.mem_ready_i = 1'b0;
    fetch_op(32'h0000_000C, 1);
    data_op(1'b0, 32'h0000_0020, 32'h0, 0);

    // Saturation of the stall counter with a fetch left waiting.
    bus.i_req_i  = 1'b1;
    bus.i_addr_i = 32'h0000_0044;
    tick();
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    #1;
    chk1("sat_preloaded", (bus.stall_cnt_o >= 32'hFFFF_FFF0), 1'b1);
    repeat (4) tick();
    chk32("sat_reach", bus.stall_cnt_o, 32'hFFFF_FFFF);
    repeat (3) tick();
    chk32("sat_hold", bus.stall_cnt_o, 32'hFFFF_FFFF);
    chk1("sat_still_waiting", bus.mem_req_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
